// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: sequences an R-type mul/div through the iterative
// multiply/divide unit. It stalls the pipeline while the operation runs,
// issues a one-cycle start pulse and then waits for the result. When the
// result arrives it writes it back. On an exception or a timeout it writes
// an exception code to rstatus instead.
module multdiv_sequencer #(
  parameter int unsigned TIMEOUT      = 40,
  parameter int unsigned RSTATUS_REG  = 30,
  parameter int unsigned MUL_EXC_CODE = 4,
  parameter int unsigned DIV_EXC_CODE = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [4:0]  opcode,
  input  logic [4:0]  alu_op,
  input  logic [4:0]  rd,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        flush,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_result_rdy,
  output logic        stall,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic [31:0] md_operand_a,
  output logic [31:0] md_operand_b,
  output logic        wb_we,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        busy
);

  localparam int unsigned     CNT_W       = $clog2(TIMEOUT + 1);
  localparam logic [4:0]      OP_RTYPE    = 5'b00000;
  localparam logic [4:0]      ALU_MUL     = 5'b00110;
  localparam logic [4:0]      ALU_DIV     = 5'b00111;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [4:0]      RSTATUS_IDX = 5'(RSTATUS_REG);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Exception code for the operation type, zero-extended to a register word.
  function automatic logic [31:0] exc_code(input logic is_div);
    return is_div ? 32'(DIV_EXC_CODE) : 32'(MUL_EXC_CODE);
  endfunction

  state_e            state_q;
  logic              is_div_q;
  logic [4:0]        rd_q;
  logic [31:0]       op_a_q;
  logic [31:0]       op_b_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              mult_q;
  logic              div_q;
  logic              we_q;
  logic [4:0]        wreg_q;
  logic [31:0]       wdata_q;
  logic              busy_q;
  logic              go;

  assign go = issue_valid & (opcode == OP_RTYPE)
            & ((alu_op == ALU_MUL) | (alu_op == ALU_DIV)) & ~flush;

  // Stall must act in the same cycle the instruction is seen, so it is combinational.
  assign stall = (state_q == S_START) | (state_q == S_WAIT) | ((state_q == S_IDLE) & go);

  assign md_ctrl_mult = mult_q;
  assign md_ctrl_div  = div_q;
  assign md_operand_a = op_a_q;
  assign md_operand_b = op_b_q;
  assign wb_we        = we_q;
  assign wb_reg       = wreg_q;
  assign wb_data      = wdata_q;
  assign busy         = busy_q;

  // Sequencer FSM with registered start pulses, writeback and latched operands.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      is_div_q <= 1'b0;
      rd_q     <= 5'd0;
      op_a_q   <= 32'd0;
      op_b_q   <= 32'd0;
      cnt_q    <= '0;
      mult_q   <= 1'b0;
      div_q    <= 1'b0;
      we_q     <= 1'b0;
      wreg_q   <= 5'd0;
      wdata_q  <= 32'd0;
      busy_q   <= 1'b0;
    end else begin
      // Pulse-type outputs fall back to zero unless a transition sets them.
      mult_q  <= 1'b0;
      div_q   <= 1'b0;
      we_q    <= 1'b0;
      wreg_q  <= 5'd0;
      wdata_q <= 32'd0;
      case (state_q)
        S_IDLE: begin
          if (go) begin
            state_q  <= S_START;
            is_div_q <= alu_op[0];
            rd_q     <= rd;
            op_a_q   <= operand_a;
            op_b_q   <= operand_b;
            mult_q   <= ~alu_op[0];
            div_q    <= alu_op[0];
            busy_q   <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_START: begin
          // The start pulse is already on the wire this cycle, even if flushed.
          cnt_q <= '0;
          if (flush) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            is_div_q <= 1'b0;
            rd_q     <= 5'd0;
            op_a_q   <= 32'd0;
            op_b_q   <= 32'd0;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (flush) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            rd_q     <= 5'd0;
            op_a_q   <= 32'd0;
            op_b_q   <= 32'd0;
          end else if (md_result_rdy) begin
            // A ready flag in the timeout cycle still delivers the real result.
            state_q <= S_DONE;
            if (md_exception) begin
              we_q    <= 1'b1;
              wreg_q  <= RSTATUS_IDX;
              wdata_q <= exc_code(is_div_q);
            end else begin
              we_q    <= (rd_q != 5'd0);
              wreg_q  <= rd_q;
              wdata_q <= md_result;
            end
          end else if (cnt_q == CNT_LAST) begin
            state_q <= S_DONE;
            we_q    <= 1'b1;
            wreg_q  <= RSTATUS_IDX;
            wdata_q <= exc_code(is_div_q);
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_DONE: begin
          // Committed: flush is ignored and the held instruction advances now.
          state_q  <= S_IDLE;
          busy_q   <= 1'b0;
          cnt_q    <= '0;
          is_div_q <= 1'b0;
          rd_q     <= 5'd0;
          op_a_q   <= 32'd0;
          op_b_q   <= 32'd0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench for multdiv_sequencer: table of directed operations,
// hand-written reset and back-to-back sequences, and randomized operations
// whose writeback is predicted from the cycle-level timing rules.
module tb_multdiv_sequencer;

  localparam int TIMEOUT = 40;

  logic        clock;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  opcode;
  logic [4:0]  alu_op;
  logic [4:0]  rd;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        flush;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_result_rdy;
  logic        stall;
  logic        md_ctrl_mult;
  logic        md_ctrl_div;
  logic [31:0] md_operand_a;
  logic [31:0] md_operand_b;
  logic        wb_we;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;

  multdiv_sequencer #(
    .TIMEOUT(TIMEOUT), .RSTATUS_REG(30), .MUL_EXC_CODE(4), .DIV_EXC_CODE(5)
  ) dut (
    .clock(clock), .reset(reset), .issue_valid(issue_valid), .opcode(opcode),
    .alu_op(alu_op), .rd(rd), .operand_a(operand_a), .operand_b(operand_b),
    .flush(flush), .md_result(md_result), .md_exception(md_exception),
    .md_result_rdy(md_result_rdy), .stall(stall), .md_ctrl_mult(md_ctrl_mult),
    .md_ctrl_div(md_ctrl_div), .md_operand_a(md_operand_a),
    .md_operand_b(md_operand_b), .wb_we(wb_we), .wb_reg(wb_reg),
    .wb_data(wb_data), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One operation: stimulus timing (cycle 0 = go cycle) plus expected writeback.
  typedef struct {
    logic        is_div;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    int          rdy_k;     // cycle of md_result_rdy, -1 = never
    logic        exc;
    logic [31:0] res;
    int          flush_f;   // cycle of flush, -1 = none
    logic        spur;      // spurious ready in the start-pulse cycle
    int          exp_wb;    // writeback (DONE) cycle, -1 = cancelled
    logic        exp_we;
    logic [4:0]  exp_reg;
    logic [31:0] exp_data;
  } op_t;

  task automatic chk(input string name, input int id, input int cyc,
                     input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s op=%0d cycle=%0d actual=0x%0h expected=0x%0h", name, id, cyc, act, exp);
    end
  endtask

  // Reference model: writeback outcome from the timing rules, in whole cycles.
  function automatic op_t model(input op_t op);
    op_t r = op;
    int  w;
    bit  e;
    if (op.rdy_k >= 2 && op.rdy_k <= TIMEOUT + 1) begin
      w = op.rdy_k + 1;
      e = op.exc;
    end else begin
      w = TIMEOUT + 2;
      e = 1'b1;
    end
    if (op.flush_f >= 1 && op.flush_f < w) begin
      r.exp_wb = -1; r.exp_we = 1'b0; r.exp_reg = 5'd0; r.exp_data = 32'd0;
    end else if (e) begin
      r.exp_wb = w; r.exp_we = 1'b1; r.exp_reg = 5'd30;
      r.exp_data = op.is_div ? 32'd5 : 32'd4;
    end else begin
      r.exp_wb = w; r.exp_we = (op.rd != 5'd0); r.exp_reg = op.rd; r.exp_data = op.res;
    end
    return r;
  endfunction

  function automatic int tail_for(input op_t op);
    int h = (op.exp_wb < 0) ? op.flush_f : op.exp_wb;
    return (op.rdy_k > h) ? (op.rdy_k - h + 1) : 2;
  endfunction

  // Drive one operation cycle by cycle and check every output against the expectation.
  task automatic run_op(input op_t op, input int id, input int tail);
    bit flushed = (op.exp_wb < 0);
    int hold_end = flushed ? op.flush_f : op.exp_wb;
    for (int c = 0; c <= hold_end + tail; c++) begin
      bit in_op = (c <= hold_end);
      issue_valid   = in_op;
      opcode        = 5'd0;
      alu_op        = op.is_div ? 5'b00111 : 5'b00110;
      rd            = op.rd;
      operand_a     = op.a;
      operand_b     = op.b;
      flush         = (c == op.flush_f);
      md_result_rdy = (c == op.rdy_k) || (op.spur && c == 1);
      md_result     = (c == 1) ? ~op.res : op.res;
      md_exception  = (c == 1) ? 1'b1 : op.exc;
      #1;
      chk("stall", id, c, 32'(stall), 32'(in_op && (flushed || c < hold_end)));
      chk("busy", id, c, 32'(busy), 32'(in_op && c >= 1));
      chk("md_ctrl_mult", id, c, 32'(md_ctrl_mult), 32'(c == 1 && !op.is_div));
      chk("md_ctrl_div", id, c, 32'(md_ctrl_div), 32'(c == 1 && op.is_div));
      chk("wb_we", id, c, 32'(wb_we), 32'(!flushed && c == op.exp_wb && op.exp_we));
      if (!flushed && c == op.exp_wb && op.exp_we) begin
        chk("wb_reg", id, c, 32'(wb_reg), 32'(op.exp_reg));
        chk("wb_data", id, c, wb_data, op.exp_data);
      end
      if (in_op && c >= 1) begin
        chk("md_operand_a", id, c, md_operand_a, op.a);
        chk("md_operand_b", id, c, md_operand_b, op.b);
      end
      @(negedge clock);
    end
    issue_valid = 1'b0; flush = 1'b0; md_result_rdy = 1'b0;
  endtask

  task automatic check_all_zero(input string name, input int cyc);
    chk({name, "_stall"}, 0, cyc, 32'(stall), 32'd0);
    chk({name, "_busy"}, 0, cyc, 32'(busy), 32'd0);
    chk({name, "_mult"}, 0, cyc, 32'(md_ctrl_mult), 32'd0);
    chk({name, "_div"}, 0, cyc, 32'(md_ctrl_div), 32'd0);
    chk({name, "_wb_we"}, 0, cyc, 32'(wb_we), 32'd0);
    chk({name, "_wb_reg"}, 0, cyc, 32'(wb_reg), 32'd0);
    chk({name, "_wb_data"}, 0, cyc, wb_data, 32'd0);
    chk({name, "_opa"}, 0, cyc, md_operand_a, 32'd0);
    chk({name, "_opb"}, 0, cyc, md_operand_b, 32'd0);
  endtask

  op_t vecs [11];

  // Guard against a hung run.
  initial begin
    #2000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t op, op2;
    vecs[0]  = '{1'b0, 5'd3,  32'd6,   32'd7, 17, 1'b0, 32'd42,         -1, 1'b0, 18, 1'b1, 5'd3,  32'd42};
    vecs[1]  = '{1'b1, 5'd5,  32'd10,  32'd0,  4, 1'b1, 32'd0,          -1, 1'b0,  5, 1'b1, 5'd30, 32'd5};
    vecs[2]  = '{1'b0, 5'd0,  32'd3,   32'd3,  3, 1'b0, 32'd9,          -1, 1'b0,  4, 1'b0, 5'd0,  32'd0};
    vecs[3]  = '{1'b0, 5'd7,  32'd1,   32'd2, -1, 1'b0, 32'd0,          -1, 1'b0, 42, 1'b1, 5'd30, 32'd4};
    vecs[4]  = '{1'b1, 5'd9,  32'd100, 32'd7, 10, 1'b0, 32'd14,          5, 1'b0, -1, 1'b0, 5'd0,  32'd0};
    vecs[5]  = '{1'b1, 5'd12, 32'd50,  32'd3, 41, 1'b0, 32'h1234,       -1, 1'b0, 42, 1'b1, 5'd12, 32'h1234};
    vecs[6]  = '{1'b0, 5'd4,  32'd2,   32'd3,  2, 1'b0, 32'hDEADBEEF,   -1, 1'b1,  3, 1'b1, 5'd4,  32'hDEADBEEF};
    vecs[7]  = '{1'b1, 5'd8,  32'd9,   32'd1,  6, 1'b0, 32'd77,          7, 1'b0,  7, 1'b1, 5'd8,  32'd77};
    vecs[8]  = '{1'b0, 5'd6,  32'd4,   32'd5,  5, 1'b0, 32'd11,          1, 1'b0, -1, 1'b0, 5'd0,  32'd0};
    vecs[9]  = '{1'b1, 5'd10, 32'd8,   32'd2, 42, 1'b0, 32'd99,         -1, 1'b0, 42, 1'b1, 5'd30, 32'd5};
    vecs[10] = '{1'b0, 5'd0,  32'd5,   32'd5,  3, 1'b1, 32'd1,          -1, 1'b0,  4, 1'b1, 5'd30, 32'd4};

    reset = 1'b1; issue_valid = 1'b0; opcode = 5'd0; alu_op = 5'd0; rd = 5'd0;
    operand_a = 32'd0; operand_b = 32'd0; flush = 1'b0; md_result = 32'd0;
    md_exception = 1'b0; md_result_rdy = 1'b0;
    repeat (3) @(negedge clock);
    check_all_zero("reset", 0);
    reset = 1'b0;
    @(negedge clock);

    // Directed table.
    for (int i = 0; i < 11; i++) run_op(vecs[i], i, tail_for(vecs[i]));

    // Non-mul/div instructions and a flushed mul never engage the sequencer.
    for (int c = 0; c < 4; c++) begin
      issue_valid = 1'b1;
      opcode      = (c == 0) ? 5'd2 : 5'd0;
      alu_op      = (c == 1) ? 5'd5 : 5'b00110;
      flush       = (c >= 2);
      md_result_rdy = (c == 3);
      #1;
      check_all_zero("nonmd", c);
      @(negedge clock);
    end
    issue_valid = 1'b0; flush = 1'b0; md_result_rdy = 1'b0;
    @(negedge clock);

    // Reset held two cycles in the middle of WAIT aborts the op.
    issue_valid = 1'b1; opcode = 5'd0; alu_op = 5'b00111; rd = 5'd5;
    operand_a = 32'd21; operand_b = 32'd3;
    #1;
    chk("rst_go_stall", 0, 0, 32'(stall), 32'd1);
    @(negedge clock);
    #1;
    chk("rst_div_pulse", 0, 1, 32'(md_ctrl_div), 32'd1);
    repeat (4) @(negedge clock);
    #1;
    chk("rst_wait_busy", 0, 5, 32'(busy), 32'd1);
    reset = 1'b1; issue_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    check_all_zero("rst_mid", 7);
    for (int c = 8; c < 13; c++) begin
      @(negedge clock);
      md_result_rdy = (c == 9);
      md_result     = 32'd123;
      #1;
      check_all_zero("rst_after", c);
    end
    md_result_rdy = 1'b0;
    @(negedge clock);

    // Back-to-back mul then div, each ready three cycles after its start pulse.
    op  = '{1'b0, 5'd11, 32'd30, 32'd41, 4, 1'b0, 32'd1230, -1, 1'b0, 5, 1'b1, 5'd11, 32'd1230};
    op2 = '{1'b1, 5'd13, 32'd90, 32'd9,  4, 1'b0, 32'd10,   -1, 1'b0, 5, 1'b1, 5'd13, 32'd10};
    run_op(op, 100, 0);
    run_op(op2, 101, 2);

    // Randomized operations checked against the model.
    for (int i = 0; i < 150; i++) begin
      int sel;
      op.is_div = 1'($urandom_range(0, 1));
      op.rd     = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      op.a      = $urandom;
      op.b      = $urandom;
      sel       = $urandom_range(0, 9);
      op.rdy_k  = (sel == 0) ? -1 : (sel == 1) ? TIMEOUT + 1 : (sel == 2) ? TIMEOUT + 2
                : $urandom_range(2, 12);
      op.exc    = ($urandom_range(0, 3) == 0);
      op.res    = $urandom;
      op.flush_f = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 14) : -1;
      op.spur   = 1'($urandom_range(0, 1));
      op = model(op);
      run_op(op, 200 + i, $urandom_range(0, 2));
    end
    repeat (2) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
Multi-cycle controller for the processor's iterative multiply/divide unit. Detects R-type mul/div in the execute stage and stalls the pipeline. Issues a one-cycle start pulse to the multdiv unit, then waits for its ready flag. Writes the result to the register file, or writes the exception code to rstatus ($r30) on overflow, divide-by-zero or timeout.

Parameters:
TIMEOUT, 40, max WAIT cycles before forced exception (>=2)
RSTATUS_REG, 30, register written on exception
MUL_EXC_CODE, 4, value written to RSTATUS_REG on mul exception/timeout
DIV_EXC_CODE, 5, value written to RSTATUS_REG on div exception/timeout

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
issue_valid  input  1  execute-stage instruction valid
opcode  input  5  instruction opcode; R-type = 00000
alu_op  input  5  R-type ALU op; mul = 00110, div = 00111
rd  input  5  destination register
operand_a  input  32  rs value
operand_b  input  32  rt value
flush  input  1  cancel in-flight op (branch/jump redirect)
md_result  input  32  multdiv result
md_exception  input  1  multdiv overflow / div-by-zero, valid with md_result_rdy
md_result_rdy  input  1  multdiv result valid, single-cycle pulse
stall  output  1  hold PC and pipeline registers
md_ctrl_mult  output  1  multiply start pulse
md_ctrl_div  output  1  divide start pulse
md_operand_a  output  32  latched operand A to multdiv
md_operand_b  output  32  latched operand B to multdiv
wb_we  output  1  register file write enable
wb_reg  output  5  write register
wb_data  output  32  write data
busy  output  1  state != IDLE

Behaviour:
- go = issue_valid & (opcode==00000) & (alu_op==00110 | alu_op==00111) & ~flush.
- State machine: IDLE, START, WAIT, DONE. The state register and all outputs except stall are registered.
- Reset: state=IDLE. All outputs 0, latched op/rd/operands 0, counter 0. Reset in any state aborts the op with no writeback and no start pulse.
- IDLE: if go, latch is_div=alu_op[0], rd, operand_a and operand_b; go to START. Otherwise stay.
- START: md_ctrl_mult=~is_div or md_ctrl_div=is_div, high for exactly this cycle. Counter cleared. md_result_rdy is ignored. Go to WAIT.
- WAIT: counter increments each cycle.
  - If md_result_rdy: capture md_result and md_exception; go to DONE.
  - Else if counter==TIMEOUT-1: force exception=1; go to DONE.
  - If ready and timeout occur in the same cycle, ready wins.
- DONE, exception: wb_we=1, wb_reg=RSTATUS_REG, wb_data=is_div ? DIV_EXC_CODE : MUL_EXC_CODE (zero-extended to 32 bits).
- DONE, no exception: wb_reg=rd, wb_data=captured result, wb_we=(rd!=0). No write to $r0.
- DONE lasts one cycle, then IDLE. wb_we is 0 in every other state.
- md_operand_a/b hold the latched values from START through DONE.
- stall (combinational) = (state==START) | (state==WAIT) | (state==IDLE & go). stall is 0 in DONE, so the held instruction advances in the writeback cycle.
- Re-trigger guard: the DONE→IDLE transition and the instruction advancing happen on the same edge. A new mul/div in the next cycle is a new instruction and starts normally.
- flush in START or WAIT: go to IDLE next cycle. No writeback; a late md_result_rdy is ignored. If flush arrives in START, the start pulse still fires that cycle.
- flush in DONE is ignored; the op is already committed.
- Latency: go at cycle 0, start pulse at cycle 1, earliest rdy at cycle 2, writeback at cycle 3. In general, rdy at cycle k gives wb_we at cycle k+1; stall is high for cycles 0..k.
- Non-mul/div instructions never assert stall or any output.

Test Plan:
- Reset held 2 cycles mid-WAIT → next cycle all outputs 0, busy=0, no wb_we, no further start pulse.
- mul rd=3, a=6, b=7; rdy at cycle 17 with result 42 → md_ctrl_mult high at cycle 1 only, stall high cycles 0–17, wb_we=1 with r3=42 at cycle 18.
- div a=10, b=0, rd=5; rdy with md_exception=1 → single write: wb_reg=30, wb_data=5, no write to r5.
- mul rd=0, result 9 → wb_we stays 0 throughout. Separately, rdy never asserted → wb r30=4 at cycle 1+TIMEOUT+1=42.
- div in WAIT, flush at cycle 5, rdy at cycle 10 → IDLE at cycle 6, stall low from cycle 6, no wb_we ever.
- Back-to-back mul then div, each with rdy 3 cycles after its start pulse → two start pulses (mult, then div), two writebacks, DONE→IDLE→START with no missed issue.
